// File: rtl/gf_seq_alu.sv
// gf_seq_alu: digit-serial integer / carry-less / GF(2^m) multiplier with valid/ready handshakes.
// Build macro GF_SEQ_EARLY_TERM_EN: MUL stops once the unconsumed bits of b are all zero.
module gf_seq_alu #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DIGIT_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    op,
  input  logic [DATA_WIDTH-1:0]         a,
  input  logic [DATA_WIDTH-1:0]         b,
  input  logic [$clog2(DATA_WIDTH):0]   polyn_grade,
  input  logic [DATA_WIDTH:0]           polyn_red_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*DATA_WIDTH-1:0]       result,
  output logic                          err
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned DW   = DIGIT_WIDTH;
  localparam int unsigned AW   = 2 * W;
  localparam int unsigned NDIG = W / DW;
  localparam int unsigned MW   = $clog2(W) + 1;
  localparam int unsigned RW   = $clog2(AW);
  localparam int unsigned CW   = $clog2(NDIG) + 1;

  typedef enum logic [1:0] {IDLE, MUL, REDUCE, DONE} state_t;

  state_t          state_q;
  logic [1:0]      op_q;
  logic [MW-1:0]   m_q;
  logic [W:0]      poly_q;
  logic [AW-1:0]   a_sh_q;
  logic [W-1:0]    b_q;
  logic [CW-1:0]   cnt_q;
  logic [RW-1:0]   red_idx_q;
  logic [AW-1:0]   acc_q;
  logic            pend_err_q;
  logic [AW-1:0]   result_q;
  logic            err_q;
  logic            out_valid_q;
  logic            in_ready_q;

  logic [AW-1:0]   pp_int;
  logic [AW-1:0]   pp_xor;
  logic [AW-1:0]   acc_mul_d;
  logic [AW-1:0]   acc_red_d;
  logic [RW-1:0]   red_sh;
  logic            mul_last;
  logic [W-1:0]    m_mask;
  logic [W:0]      p_mask;
  logic            grade_bad;

  // Operand masks for field ops: element bits [m-1:0], polynomial bits [m:0]
  always_comb begin
    m_mask = '0;
    p_mask = '0;
    for (int i = 0; i < W; i++) m_mask[i] = (MW'(i) < polyn_grade);
    for (int i = 0; i <= W; i++) p_mask[i] = (MW'(i) <= polyn_grade);
    grade_bad = (polyn_grade < MW'(2)) || (polyn_grade > MW'(W));
  end

  // One digit of partial product, plus one bit-step of reduction
  always_comb begin
    pp_int = '0;
    pp_xor = '0;
    for (int j = 0; j < DW; j++) begin
      if (b_q[j]) begin
        pp_int = pp_int + (a_sh_q << j);
        pp_xor = pp_xor ^ (a_sh_q << j);
      end
    end
    acc_mul_d = (op_q == 2'd0) ? (acc_q + pp_int) : (acc_q ^ pp_xor);
`ifdef GF_SEQ_EARLY_TERM_EN
    mul_last = ((b_q >> DW) == '0) || (cnt_q == CW'(NDIG - 1));
`else
    mul_last = (cnt_q == CW'(NDIG - 1));
`endif
    red_sh    = red_idx_q - RW'(m_q);
    acc_red_d = acc_q;
    if (acc_q[red_idx_q]) acc_red_d = acc_q ^ (AW'(poly_q) << red_sh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      m_q         <= '0;
      poly_q      <= '0;
      a_sh_q      <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      red_idx_q   <= '0;
      acc_q       <= '0;
      pend_err_q  <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q       <= op;
            m_q        <= polyn_grade;
            poly_q     <= op[1] ? (polyn_red_in & p_mask) : polyn_red_in;
            a_sh_q     <= AW'(op[1] ? (a & m_mask) : a);
            b_q        <= (op == 2'd3) ? (a & m_mask) : (op == 2'd2) ? (b & m_mask) : b;
            acc_q      <= '0;
            cnt_q      <= '0;
            pend_err_q <= op[1] && grade_bad;
            in_ready_q <= 1'b0;
            state_q    <= MUL;
          end
        end
        MUL: begin
          if (pend_err_q) begin
            // Bad field degree: single pass-through cycle, then report
            result_q    <= '0;
            err_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            acc_q  <= acc_mul_d;
            a_sh_q <= a_sh_q << DW;
            b_q    <= b_q >> DW;
            cnt_q  <= cnt_q + CW'(1);
            if (mul_last) begin
              if (op_q[1]) begin
                red_idx_q <= RW'({m_q, 1'b0} - (MW + 1)'(2));
                state_q   <= REDUCE;
              end else begin
                result_q    <= acc_mul_d;
                err_q       <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= DONE;
              end
            end
          end
        end
        REDUCE: begin
          acc_q     <= acc_red_d;
          red_idx_q <= red_idx_q - RW'(1);
          if (red_idx_q == RW'(m_q)) begin
            result_q    <= acc_red_d;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;

endmodule

// File: doc/gf_seq_alu.md
# gf_seq_alu

Sequential, digit-serial multiplier for integer, carry-less and GF(2^m) arithmetic. It succeeds the combinational carry-less multiply/reduce path: the field degree m is chosen per operation at runtime, the digit width is a parameter, and operands and results move through valid/ready handshakes. The block sits between the operand scheduler and the result bus of the finite-field datapath, in front of the reduction and verification logic.

## Interface
- DATA_WIDTH, 32, operand width W; also the maximum field degree.
- DIGIT_WIDTH, 4, bits of operand b consumed per MUL cycle. W % DIGIT_WIDTH must be 0. NDIG = W/DIGIT_WIDTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request; high only in IDLE.
- op  in  2  0 integer mult, 1 carry-less mult, 2 GF mult, 3 GF square (b ignored).
- a, b  in  W  operands.
- polyn_grade  in  $clog2(W)+1  field degree m; used for op 2/3 only.
- polyn_red_in  in  W+1  irreducible polynomial including the x^m term.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  2W  product (op 0/1) or field element in bits [m-1:0], upper bits zero (op 2/3).
- err  out  1  qualifies result; set when op 2/3 has m<2 or m>W.

## Operation
- FSM: IDLE -> MUL -> (REDUCE if op 2/3) -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch op, m, poly and a. Latch b, or a when op=3. For op 2/3, mask operands to bits [m-1:0]. Clear the accumulator and go to MUL.
- Invalid degree (op 2/3, m<2 or m>W): go straight to DONE with err=1 and result=0.
- MUL: each cycle consumes the next DIGIT_WIDTH bits of b, LSB first. The partial product a·digit is shifted into place and combined into the 2W accumulator: integer add for op 0, XOR for op 1/2/3. Runs NDIG cycles.
- REDUCE: one bit per cycle, for index i from 2m-2 down to m. If acc[i]=1, XOR in poly shifted left by i-m. Runs m-1 cycles.
- DONE: out_valid=1. result and err are held stable until out_valid&&out_ready, then return to IDLE.
- in_valid is ignored outside IDLE; there is no queueing.
- Integer product never overflows 2W bits.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, err=0. The accumulator and all latched operands are cleared.
- Reset asserted in any state aborts the operation. It takes effect at the next edge; no result is produced.
- Latency is measured from the accepting edge to the first cycle with out_valid=1:
  - op 0/1: NDIG cycles.
  - op 2/3: NDIG + m - 1 cycles.
  - err case: 1 cycle.
- Minimum initiation interval is latency + 1 cycle (the DONE handshake cycle returns to IDLE).
- out_ready may be high before out_valid; the handshake completes in the first DONE cycle.

## Configuration
- GF_SEQ_EARLY_TERM_EN defined:
  - MUL ends after the cycle in which the remaining unconsumed bits of b are all zero. b=0 still takes one MUL cycle.
  - REDUCE is unchanged.
  - Latency becomes data-dependent: op 0/1 use ceil((msb(b)+1)/DIGIT_WIDTH) cycles, minimum 1.
- Undefined: MUL always runs exactly NDIG cycles.
- Results are bit-identical in both builds.

## Test plan
All scenarios use W=8, DIGIT_WIDTH=2 (NDIG=4).
- op 0, a=200, b=100 -> result=0x4E20, err=0, out_valid 4 cycles after accept; in_ready=0 throughout.
- op 1, a=0x57, b=0x83 -> result=0x2B79 after 4 cycles. op 2 with the same operands, m=8, poly=0x11B -> result=0x00C1 after 11 cycles.
- op 3, a=0x80, m=8, poly=0x11B -> result=0x009A (x^14 reduced). op 2, m=1 -> err=1, result=0, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid -> result stable, in_ready=0, no new accept. Release -> back to IDLE next cycle.
- Reset asserted in the 2nd MUL cycle -> next cycle IDLE, out_valid=0, result=0. A following op 0, a=3, b=5 -> result=15.
- With GF_SEQ_EARLY_TERM_EN: op 0, a=0xFF, b=0x03 -> result=0x02FD, latency 1. Without the macro, the same operation has latency 4 and the same result.
